// File: rtl/data_memory_sized_if.sv
// Request/response bus between the MEM stage (master) and the sized data memory (slave).
// Handshake: a request is accepted on a rising clock edge where Req && Ready are both high;
// MemWrite, MemRead, Address, WriteData, Size and Unsigned are sampled on that edge only.
// Done is a one-cycle completion pulse. Fault and ReadData are valid while Done is high.
// dbg_state mirrors the memory FSM state (0 IDLE, 1 WAIT, 2 RESP).
interface data_memory_sized_if;
    logic        Req;
    logic        Ready;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        Done;
    logic        Fault;
    logic [1:0]  dbg_state;

    modport master (
        output Req, MemWrite, MemRead, Address, WriteData, Size, Unsigned,
        input  Ready, ReadData, Done, Fault, dbg_state
    );

    modport slave (
        input  Req, MemWrite, MemRead, Address, WriteData, Size, Unsigned,
        output Ready, ReadData, Done, Fault, dbg_state
    );
endinterface

// File: rtl/data_memory_sized.sv
// Sized data memory: DEPTH x 32-bit words with request/ready handshake, WAIT_STATES
// busy cycles per access, byte/half/word lane-masked stores, sign/zero-extended loads
// and fault reporting. Optional macro DMEM_ALIGN_CHECK_EN makes misaligned half/word
// accesses fault; without it the low address bits below the access size are ignored.
module data_memory_sized #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    data_memory_sized_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [3:0]  WS_M1   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [30:0] DEPTH_W = 31'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        accept;
    logic        enter_resp;

    // Holding registers for the accepted request
    logic        we_q, re_q, uns_q;
    logic [31:0] addr_q, wd_q;
    logic [1:0]  size_q;

    // Fields used for decode: live inputs while idle (only matters with zero wait states)
    logic        cur_we, cur_re, cur_uns;
    logic [31:0] cur_addr, cur_wd;
    logic [1:0]  cur_size;

    logic [AW-1:0] word_idx;
    logic          range_fault, align_fault, fault;
    logic [31:0]   old_word, new_word, lane_data, load_val, rdata_n;
    logic [3:0]    byte_en;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic          do_write;

    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] mem [DEPTH];

    assign bus.Ready     = Rst_n && (state == IDLE);
    assign accept        = bus.Req && bus.Ready;
    assign bus.Done      = (state == RESP);
    assign bus.Fault     = (state == RESP) && fault_q;
    assign bus.ReadData  = rdata_q;
    assign bus.dbg_state = state;

    // FSM state and wait counter registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state, counter and the "entering RESP" strobe that commits the access
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_n    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = WS_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_n    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Capture request fields at accept; later input changes are ignored
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            uns_q  <= 1'b0;
            addr_q <= 32'd0;
            wd_q   <= 32'd0;
            size_q <= 2'd0;
        end else if (accept) begin
            we_q   <= bus.MemWrite;
            re_q   <= bus.MemRead;
            uns_q  <= bus.Unsigned;
            addr_q <= bus.Address;
            wd_q   <= bus.WriteData;
            size_q <= bus.Size;
        end
    end

    // Select the request fields being decoded this cycle
    always_comb begin
        if (state == IDLE) begin
            cur_we   = bus.MemWrite;
            cur_re   = bus.MemRead;
            cur_uns  = bus.Unsigned;
            cur_addr = bus.Address;
            cur_wd   = bus.WriteData;
            cur_size = bus.Size;
        end else begin
            cur_we   = we_q;
            cur_re   = re_q;
            cur_uns  = uns_q;
            cur_addr = addr_q;
            cur_wd   = wd_q;
            cur_size = size_q;
        end
    end

    // Fault decode, lane masking and load extraction
    always_comb begin
        word_idx    = cur_addr[AW+1:2];
        range_fault = ({1'b0, cur_addr[31:2]} >= DEPTH_W);
`ifdef DMEM_ALIGN_CHECK_EN
        align_fault = ((cur_size == 2'b01) && cur_addr[0]) ||
                      ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
        align_fault = 1'b0;
`endif
        fault = (cur_size == 2'b11) || range_fault || (cur_re && cur_we) || align_fault;

        old_word = mem[word_idx];

        byte_en   = 4'b0000;
        lane_data = cur_wd;
        case (cur_size)
            2'b00: begin
                byte_en   = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wd[7:0]}};
            end
            2'b01: begin
                byte_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wd[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                lane_data = cur_wd;
            end
            default: begin
                byte_en   = 4'b0000;
                lane_data = cur_wd;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            new_word[8*i +: 8] = byte_en[i] ? lane_data[8*i +: 8] : old_word[8*i +: 8];
        end

        case (cur_addr[1:0])
            2'b00:   byte_sel = old_word[7:0];
            2'b01:   byte_sel = old_word[15:8];
            2'b10:   byte_sel = old_word[23:16];
            default: byte_sel = old_word[31:24];
        endcase
        half_sel = cur_addr[1] ? old_word[31:16] : old_word[15:0];

        case (cur_size)
            2'b00:   load_val = cur_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = cur_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            2'b10:   load_val = old_word;
            default: load_val = 32'd0;
        endcase

        rdata_n  = (fault || !cur_re) ? 32'd0 : load_val;
        do_write = enter_resp && cur_we && !fault;
    end

    // Response registers, loaded at the edge that enters RESP
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= rdata_n;
            fault_q <= fault;
        end
    end

    // Memory array write; contents are not reset and survive Rst_n
    always_ff @(posedge Clk) begin
        if (do_write) begin
            mem[word_idx] <= new_word;
        end
    end
endmodule

// File: doc/data_memory_sized.md
# data_memory_sized

Parametrised successor to the single-cycle 1K×32 data memory. It adds a request/ready handshake, a configurable number of wait states to model slow memory, byte/halfword/word stores with lane masking, and sign- or zero-extended loads. It also reports faulting accesses. It sits on the pipelined datapath's MEM stage; the stage stalls while `Ready` is low.

## Interface
- `DEPTH`, 1024: number of 32-bit words; must be a power of two ≥ 4; `AW = $clog2(DEPTH)`.
- `WAIT_STATES`, 2: extra busy cycles per access, 0..15.
- `Clk`  in  1  the block's only clock, rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Req`  in  1  access request; accepted when `Req && Ready` at a rising edge.
- `Ready`  out  1  high when idle and able to accept a request.
- `MemWrite`  in  1  store request, sampled at accept.
- `MemRead`  in  1  load request, sampled at accept.
- `Address`  in  32  byte address, sampled at accept.
- `WriteData`  in  32  store data, right-aligned, sampled at accept.
- `Size`  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- `Unsigned`  in  1  load extension: 1 zero-extend, 0 sign-extend.
- `ReadData`  out  32  registered load result; held until the next `Done`.
- `Done`  out  1  one-cycle pulse marking access completion.
- `Fault`  out  1  one-cycle pulse, coincident with `Done`, when the access faulted.

## Operation
- **FSM states**: IDLE, WAIT, RESP.
  - IDLE → WAIT on accept when `WAIT_STATES > 0`, loading the counter with `WAIT_STATES-1`.
  - IDLE → RESP on accept when `WAIT_STATES == 0`.
  - WAIT decrements the counter; WAIT → RESP when the counter is 0.
  - RESP → IDLE unconditionally.
- `Ready` = (state == IDLE). `Done` = (state == RESP).
- All request fields are captured into holding registers at accept. Input changes after accept have no effect.
- **Word index**: `Address[AW+1:2]`. Lanes are little-endian; byte lane = `Address[1:0]`, half lane = `Address[1]`.
- **Fault conditions**, evaluated on the captured fields:
  - `Size == 11`
  - `Address[31:2] >= DEPTH`
  - `MemRead && MemWrite`
  - misalignment (half with `Address[0]`, word with `Address[1:0] != 0`); only when the `_EN` macro is defined.
- A faulted access writes nothing, sets `ReadData` to 0, and pulses `Fault` together with `Done`.
- **Store**:
  - Only the addressed lanes change: byte → `WriteData[7:0]`, half → `WriteData[15:0]`, word → all 32 bits.
  - The other bytes of the word are preserved.
- **Load**:
  - The selected byte or half is right-aligned, then extended per `Unsigned`; a word is passed through unchanged.
- A request with neither `MemRead` nor `MemWrite` completes normally, with `ReadData` = 0 and no write.

## Timing
- **Reset values**: `Ready`=1 after release (0 while `Rst_n` is low), `Done`=0, `Fault`=0, `ReadData`=0, state IDLE, counter 0.
- The memory array is not reset. Contents survive reset.
- Accept at edge T; `Done` is high during cycle T+`WAIT_STATES`+1 (after that edge), and `Ready` is high again the following cycle.
- Throughput: one access per `WAIT_STATES`+2 cycles.
- The store commits, and `ReadData` and `Fault` are registered, at the edge that enters RESP. A load issued right after a store to the same word returns the new data.
- `Req` while `Ready` is low is ignored. It is not queued; the requester must hold `Req` until accepted.
- Reset asserted mid-access returns to IDLE immediately. An uncommitted store is dropped, and no `Done` is issued for it.
- Word at index `DEPTH-1` is legal. `Address[31:2] == DEPTH` faults; it does not wrap.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: misaligned half/word accesses fault, with no write and `ReadData`=0.
- `DMEM_ALIGN_CHECK_EN` undefined: low address bits below the access size are ignored.
  - Half uses `Address[1]` only; word uses lane 0.
  - Misalignment is never a fault; the other fault conditions still apply.

## Test plan
- **Reset**: `WAIT_STATES`=2, `Rst_n` low then high → `Ready`=1, `Done`=0, `Fault`=0, `ReadData`=0.
- **Word store/load**: store word 0xDEADBEEF to 0x10, then load word 0x10 → `Done` 3 cycles after each accept, `ReadData`=0xDEADBEEF, `Fault`=0.
- **Byte/half lanes**: after the above, store byte 0x5A to 0x11, then:
  - load word 0x10 → 0xDEAD5AEF
  - load signed half 0x12 → 0xFFFFDEAD
  - load unsigned byte 0x13 → 0x000000DE
- **Faults**: each of the following → `Fault`=`Done`=1 for one cycle, `ReadData`=0, memory unchanged:
  - word load at 0x12 (with the macro)
  - `Size`=11
  - `Address`=`DEPTH`*4
  - `MemRead` and `MemWrite` both set
- **Handshake**: hold `Req` continuously with changing `Address` while busy → only addresses sampled in `Ready` cycles are serviced; accept spacing is `WAIT_STATES`+2.
- **Reset mid-store**: assert `Rst_n` low one cycle after accepting a store of 0x12345678 to 0x20 → no `Done`; a subsequent load of 0x20 returns the prior contents.
